// File: rtl/stp_pkg.sv
// Shared stopwatch definitions: FSM state encodings, default debounce length
// and the per-state control output decode.
package stp_pkg;

  localparam int unsigned STP_DEBOUNCE_CYCLES = 20;
  localparam int unsigned STATE_W             = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUNNING = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSED  = 2'd2;
  localparam logic [STATE_W-1:0] ST_LAP     = 2'd3;

  typedef struct packed {
    logic en;
    logic stop;
    logic lap_freeze;
  } stp_ctrl_t;

  // Counter control levels implied by a state
  function automatic stp_ctrl_t stp_state_ctrl(input logic [STATE_W-1:0] st);
    stp_ctrl_t c;
    c = '{en: 1'b0, stop: 1'b0, lap_freeze: 1'b0};
    case (st)
      ST_IDLE:    c.stop = 1'b1;
      ST_RUNNING: c.en   = 1'b1;
      ST_LAP: begin
        c.en         = 1'b1;
        c.lap_freeze = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stp_debounce.sv
// One push-button front end: 2-flop synchronizer, counting debouncer and
// rising-edge detector producing a single-cycle press pulse.
module stp_debounce
  import stp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = STP_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept the new level on the Nth consecutive differing sample; the count
  // never exceeds CNT_LAST and any agreeing sample clears it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q2 != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync_q2;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press   <= level_d & ~level_q;
    end
  end

endmodule

// File: rtl/stp_ctrl_fsm.sv
// Stopwatch control FSM: turns debounced start/stop, reset and lap presses
// into counter enable, hold, clear and display-freeze controls.
module stp_ctrl_fsm
  import stp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = STP_DEBOUNCE_CYCLES
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               btn_start_stop,
  input  logic               btn_reset,
  input  logic               btn_lap,
  input  logic               mode_stopwatch,
  output logic               en,
  output logic               stop,
  output logic               rst_counters,
  output logic               lap_freeze,
  output logic [STATE_W-1:0] state
);

  logic               press_start_stop;
  logic               press_reset;
  logic               press_lap;
  logic [STATE_W-1:0] state_d;
  logic               rst_counters_d;
  stp_ctrl_t          ctrl_d;

  stp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .CLK   (CLK),
    .rst   (rst),
    .btn   (btn_start_stop),
    .press (press_start_stop)
  );

  stp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .CLK   (CLK),
    .rst   (rst),
    .btn   (btn_reset),
    .press (press_reset)
  );

  stp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .CLK   (CLK),
    .rst   (rst),
    .btn   (btn_lap),
    .press (press_lap)
  );

  // Next state; one press per cycle is honoured in order reset > start_stop > lap
  always_comb begin
    state_d        = state;
    rst_counters_d = 1'b0;
    if (mode_stopwatch) begin
      if (press_reset) begin
        case (state)
          ST_IDLE, ST_PAUSED: begin
            state_d        = ST_IDLE;
            rst_counters_d = ~rst_counters;
          end
          ST_LAP:  state_d = ST_RUNNING;
          default: ;
        endcase
      end else if (press_start_stop) begin
        case (state)
          ST_IDLE:    state_d = ST_RUNNING;
          ST_RUNNING: state_d = ST_PAUSED;
          ST_PAUSED:  state_d = ST_RUNNING;
          ST_LAP:     state_d = ST_PAUSED;
          default:    state_d = ST_IDLE;
        endcase
      end else if (press_lap) begin
        case (state)
          ST_RUNNING: state_d = ST_LAP;
          ST_LAP:     state_d = ST_RUNNING;
          default:    ;
        endcase
      end
    end
  end

  assign ctrl_d = stp_state_ctrl(state_d);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= ST_IDLE;
      en           <= 1'b0;
      stop         <= 1'b1;
      lap_freeze   <= 1'b0;
      rst_counters <= 1'b0;
    end else begin
      state        <= state_d;
      en           <= ctrl_d.en;
      stop         <= ctrl_d.stop;
      lap_freeze   <= ctrl_d.lap_freeze;
      rst_counters <= rst_counters_d;
    end
  end

endmodule

// File: doc/stp_ctrl_fsm.md
STP_CTRL_FSM -- requirements
Module: stp_ctrl_fsm

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, SHALL set the number of consecutive stable CLK samples needed to accept a button level change (20 ms at 1 kHz).
REQ-002 CLK  input  1  system clock, 1 kHz; single clock domain, all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_start_stop  input  1  raw asynchronous push-button, active-high.
REQ-005 btn_reset  input  1  raw asynchronous push-button, active-high.
REQ-006 btn_lap  input  1  raw asynchronous push-button, active-high.
REQ-007 mode_stopwatch  input  1  high while the clock is in stopwatch mode; low means all buttons are ignored.
REQ-008 en  output  1  count enable to the stopwatch seconds counter.
REQ-009 stop  output  1  level hold-at-zero to the stopwatch seconds counter.
REQ-010 rst_counters  output  1  one-cycle clear pulse to all stopwatch counters.
REQ-011 lap_freeze  output  1  display hold; high means the display keeps the lap value while counting continues.
REQ-012 state  output  2  current FSM state encoding.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector that produces a single-cycle press pulse.
REQ-014 The debouncer SHALL update its level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any sample equal to the current level SHALL clear the count.
REQ-015 Latency from a clean raw rising edge to the FSM state change SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-016 A held button SHALL produce exactly one press pulse; a release followed by a new press SHALL produce another.
REQ-017 FSM states and encodings SHALL be IDLE=0, RUNNING=1, PAUSED=2, LAP=3.
REQ-018 Outputs are registered and SHALL take these values by state: IDLE en=0 stop=1 lap_freeze=0; RUNNING en=1 stop=0 lap_freeze=0; PAUSED en=0 stop=0 lap_freeze=0; LAP en=1 stop=0 lap_freeze=1.
REQ-019 start_stop press: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING, LAP->PAUSED (lap_freeze drops).
REQ-020 lap press: RUNNING->LAP, LAP->RUNNING; ignored in IDLE and PAUSED.
REQ-021 reset press: PAUSED->IDLE and IDLE->IDLE, each with rst_counters high for exactly one cycle on the cycle state becomes IDLE; LAP->RUNNING with no rst_counters; ignored in RUNNING.
REQ-022 Simultaneous press pulses in one cycle SHALL be resolved by priority reset > start_stop > lap; lower-priority pulses in that cycle SHALL be discarded.
REQ-023 While mode_stopwatch=0, press pulses SHALL be discarded and state and outputs SHALL hold; debouncers keep tracking button levels.
REQ-024 A button held when mode_stopwatch rises SHALL NOT generate a press pulse.
REQ-025 rst_counters SHALL never be high for two consecutive cycles.

Reset
REQ-026 While rst=1 on a clock edge: state=IDLE, en=0, stop=1, rst_counters=0, lap_freeze=0, synchronizers and debounced levels=0, and debounce counters=0.
REQ-027 rst asserted mid-debounce or mid-state SHALL discard any pending press; the first press counts from a full DEBOUNCE_CYCLES after rst deasserts.

Structure
REQ-028 The state encodings SHALL live in the shared stopwatch package/header stp_pkg, together with the default DEBOUNCE_CYCLES constant.
REQ-029 The synchronizer, debouncer and edge detector SHALL form one sub-module, stp_debounce, with parameter DEBOUNCE_CYCLES, instantiated three times.
REQ-030 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) and SHALL saturate, never wrap.

Verification (benches use DEBOUNCE_CYCLES=4)
REQ-031 After rst, raise btn_start_stop cleanly -> state=RUNNING, en=1, stop=0 exactly 7 cycles later.
REQ-032 btn_lap glitch lasting 3 cycles in RUNNING -> no state change; a 10-cycle press -> LAP with lap_freeze=1 and en=1, a second press -> RUNNING.
REQ-033 Press start_stop in RUNNING, then press reset -> PAUSED, then IDLE with rst_counters high for exactly 1 cycle and stop=1.
REQ-034 btn_reset and btn_start_stop rise in the same cycle while PAUSED -> IDLE with one rst_counters pulse; start_stop is ignored.
REQ-035 With mode_stopwatch=0 in RUNNING, press start_stop -> state stays RUNNING; raise mode_stopwatch while the button is still held -> no transition.
REQ-036 Assert rst for 1 cycle in LAP while btn_lap is mid-debounce -> IDLE, en=0, stop=1, lap_freeze=0, and no press pulse follows.
